// File: rtl/board_win_scanner_if.sv
// Handshake and result bundle between the game-control FSM (master) and the
// sequential N x N winner scanner (slave).
interface board_win_scanner_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned LW = $clog2(2 * N + 2)
);
    logic                 start;
    logic [2*N*N-1:0]     board;
    logic                 busy;
    logic                 done;
    logic                 win;
    logic [1:0]           who;
    logic [LW-1:0]        win_line;
    logic                 draw;
    logic                 err;

    modport master (
        output start, board,
        input  busy, done, win, who, win_line, draw, err
    );

    modport slave (
        input  start, board,
        output busy, done, win, who, win_line, draw, err
    );
endinterface

// File: rtl/board_win_scanner.sv
// Sequential N x N tic-tac-toe winner scanner: one line per clock (rows, columns,
// main diagonal, anti-diagonal), early exit on the first winning line.
module board_win_scanner #(
    parameter int unsigned N  = 3,
    parameter int unsigned LW = $clog2(2 * N + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    board_win_scanner_if.slave bus
);
    localparam int unsigned NumLines = 2 * N + 2;
    localparam int unsigned NumCells = N * N;
    localparam logic [LW-1:0] LastLine = LW'(2 * N + 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StScan = 1'b1;

    // Flat cell index of the k-th cell of line l.
    function automatic int unsigned cell_idx(input int unsigned l, input int unsigned k);
        if (l < N)           return l * N + k;
        else if (l < 2 * N)  return k * N + (l - N);
        else if (l == 2 * N) return k * N + k;
        else                 return k * N + (N - 1 - k);
    endfunction

    logic [0:0]         state_q, state_d;
    logic [2*N*N-1:0]   snap_q, snap_d;
    logic [LW-1:0]      line_q, line_d;
    logic               done_q, done_d;
    logic               win_q, win_d;
    logic [1:0]         who_q, who_d;
    logic [LW-1:0]      win_line_q, win_line_d;
    logic               draw_q, draw_d;
    logic               err_q, err_d;

    logic [NumLines-1:0] line_ok;
    logic [1:0]          line_who [NumLines];
    logic [NumCells-1:0] cell_err;
    logic [NumCells-1:0] cell_empty;
    logic                any_err;
    logic                snap_draw;

    // A line wins when every cell matches its first cell and that cell is X or O.
    for (genvar l = 0; l < NumLines; l++) begin : g_line
        localparam int unsigned Idx0 = cell_idx(l, 0);
        logic [N-1:0] eq;
        for (genvar k = 0; k < N; k++) begin : g_cell
            localparam int unsigned Idx = cell_idx(l, k);
            assign eq[k] = (snap_q[2*Idx +: 2] == snap_q[2*Idx0 +: 2]);
        end
        assign line_who[l] = snap_q[2*Idx0 +: 2];
        assign line_ok[l]  = (&eq) && (line_who[l] == 2'b01 || line_who[l] == 2'b10);
    end

    for (genvar i = 0; i < NumCells; i++) begin : g_flags
        assign cell_err[i]   = (snap_q[2*i +: 2] == 2'b11);
        assign cell_empty[i] = (snap_q[2*i +: 2] == 2'b00);
    end

    assign any_err   = |cell_err;
    assign snap_draw = !any_err && !(|cell_empty);

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        line_d     = line_q;
        done_d     = 1'b0;
        win_d      = win_q;
        who_d      = who_q;
        win_line_d = win_line_q;
        draw_d     = draw_q;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    snap_d     = bus.board;
                    win_d      = 1'b0;
                    who_d      = 2'b00;
                    win_line_d = '0;
                    draw_d     = 1'b0;
                    err_d      = 1'b0;
                    line_d     = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (line_ok[line_q]) begin
                    win_d      = 1'b1;
                    who_d      = line_who[line_q];
                    win_line_d = line_q;
                    draw_d     = 1'b0;
                    err_d      = any_err;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end else if (line_q == LastLine) begin
                    win_d   = 1'b0;
                    draw_d  = snap_draw;
                    err_d   = any_err;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    line_d = line_q + LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            snap_q     <= '0;
            line_q     <= '0;
            done_q     <= 1'b0;
            win_q      <= 1'b0;
            who_q      <= 2'b00;
            win_line_q <= '0;
            draw_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            line_q     <= line_d;
            done_q     <= done_d;
            win_q      <= win_d;
            who_q      <= who_d;
            win_line_q <= win_line_d;
            draw_q     <= draw_d;
            err_q      <= err_d;
        end
    end

    assign bus.busy     = (state_q == StScan);
    assign bus.done     = done_q;
    assign bus.win      = win_q;
    assign bus.who      = who_q;
    assign bus.win_line = win_line_q;
    assign bus.draw     = draw_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_board_win_scanner.sv
// Directed bench for board_win_scanner: N=3 and N=4 instances, hand-computed
// latencies and results checked with immediate assertions.
module tb_board_win_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    board_win_scanner_if #(.N(3)) if3 ();
    board_win_scanner_if #(.N(4)) if4 ();

    board_win_scanner #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    board_win_scanner #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] b3(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // Drives start for one edge (E0); returns at the negedge after E0.
    task automatic start3(input logic [17:0] b);
        @(negedge clk);
        if3.board = b;
        if3.start = 1'b1;
        @(posedge clk);
        #1;
        check("busy3_after_start", if3.busy, 1);
        @(negedge clk);
        if3.start = 1'b0;
    endtask

    task automatic start4(input logic [31:0] b);
        @(negedge clk);
        if4.board = b;
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        check("busy4_after_start", if4.busy, 1);
        @(negedge clk);
        if4.start = 1'b0;
    endtask

    // Counts edges until done; a timeout shows up as a latency mismatch.
    task automatic wait3(input string tag, input int exp_cyc);
        int cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!if3.done && cyc < 40);
        check(tag, cyc, exp_cyc);
        check({tag, "_busy"}, if3.busy, 0);
    endtask

    task automatic wait4(input string tag, input int exp_cyc);
        int cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!if4.done && cyc < 40);
        check(tag, cyc, exp_cyc);
        check({tag, "_busy"}, if4.busy, 0);
    endtask

    task automatic res3(input string tag, input logic w, input logic [1:0] wh,
                        input logic [2:0] ln, input logic dr, input logic er);
        check({tag, "_win"}, if3.win, w);
        check({tag, "_who"}, if3.who, wh);
        check({tag, "_line"}, if3.win_line, ln);
        check({tag, "_draw"}, if3.draw, dr);
        check({tag, "_err"}, if3.err, er);
    endtask

    task automatic res4(input string tag, input logic w, input logic [1:0] wh,
                        input logic [3:0] ln, input logic dr, input logic er);
        check({tag, "_win"}, if4.win, w);
        check({tag, "_who"}, if4.who, wh);
        check({tag, "_line"}, if4.win_line, ln);
        check({tag, "_draw"}, if4.draw, dr);
        check({tag, "_err"}, if4.err, er);
    endtask

    initial begin
        logic [31:0] col2o;
        col2o = '0;
        for (int i = 2; i < 16; i += 4) col2o[2*i +: 2] = 2'b10;

        if3.start = 1'b0;
        if3.board = '0;
        if4.start = 1'b0;
        if4.board = '0;

        // Reset state
        #12;
        check("rst3_busy", if3.busy, 0);
        check("rst3_done", if3.done, 0);
        res3("rst3", 0, 2'b00, 3'd0, 0, 0);
        check("rst4_busy", if4.busy, 0);
        check("rst4_done", if4.done, 0);
        res4("rst4", 0, 2'b00, 4'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Middle row X -> line 1 at E0+2
        start3(b3(0, 0, 0, 1, 1, 1, 0, 0, 0));
        wait3("midrow_lat", 2);
        res3("midrow", 1, 2'b01, 3'd1, 0, 0);
        @(posedge clk);
        #1;
        check("midrow_done_pulse", if3.done, 0);
        check("midrow_hold_win", if3.win, 1);

        // Anti-diagonal O -> line 7 at E0+8
        start3(b3(0, 0, 2, 0, 2, 0, 2, 0, 0));
        wait3("anti_lat", 8);
        res3("anti", 1, 2'b10, 3'd7, 0, 0);

        // Full board, no win -> draw at E0+8
        start3(b3(1, 2, 1, 1, 2, 2, 2, 1, 1));
        wait3("draw_lat", 8);
        res3("draw", 0, 2'b00, 3'd0, 1, 0);

        // Row 0 and column 0 both X, cell 8 illegal -> lowest line, err set
        start3(b3(1, 1, 1, 1, 0, 0, 1, 0, 3));
        wait3("multi_lat", 1);
        res3("multi", 1, 2'b01, 3'd0, 0, 1);

        // Empty board; board change and second start at E0+2 are ignored
        start3(b3(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        if3.board = b3(1, 1, 1, 0, 0, 0, 0, 0, 0);
        if3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if3.start = 1'b0;
        wait3("ign_lat", 6);
        res3("ign", 0, 2'b00, 3'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("ign_no_second_done", {if3.done, if3.busy}, 0);
        end

        // N=4, column 2 O -> line 6 at E0+7
        start4(col2o);
        wait4("col4_lat", 7);
        res4("col4", 1, 2'b10, 4'd6, 0, 0);

        // Same scan aborted by reset at E0+3
        start4(col2o);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", if4.busy, 0);
        check("abort_done", if4.done, 0);
        res4("abort", 0, 2'b00, 4'd0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", if4.done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start4(col2o);
        wait4("rescan_lat", 7);
        res4("rescan", 1, 2'b10, 4'd6, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/board_win_scanner.md
# board_win_scanner

Sequential, parametrised N×N tic-tac-toe winner detector that replaces the fixed 3×3 combinational detector. It snapshots a board on `start` and evaluates one line per clock: rows, then columns, then both diagonals. It stops at the first winning line and reports the winner, the index of the winning line, a draw flag and an illegal-encoding flag. It sits between the board-state register file and the game-control FSM, which issues `start` after every accepted move.

## Interface
- `N`, default 3: board side length; legal range 3..8.
- `LW`, default `$clog2(2*N+2)`: width of the line index (derived; do not override).
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request a scan; sampled only while idle.
- `board`, in, 2·N·N: cell (r,c) at bits [2i+1:2i], where i = r·N+c. Encoding: 00 empty, 01 X, 10 O, 11 illegal.
- `busy`, out, 1: scan in progress.
- `done`, out, 1: one-cycle pulse; results are valid from this cycle.
- `win`, out, 1: a winning line was found.
- `who`, out, 2: winner code (01/10); 00 if no win.
- `win_line`, out, LW: index of the winning line; 0 if no win.
- `draw`, out, 1: no win, no empty cell and no illegal cell.
- `err`, out, 1: at least one cell is encoded 11.

## Operation
- FSM has two states.
  - IDLE: `busy`=0.
  - SCAN: `busy`=1.
- Line index L:
  - 0..N-1: row L.
  - N..2N-1: column L-N.
  - 2N: main diagonal (i, i).
  - 2N+1: anti-diagonal (i, N-1-i).
- IDLE, `start`=1:
  - copy `board` into an internal snapshot;
  - clear `win`, `who`, `win_line`, `draw`, `err`;
  - set L=0 and go to SCAN.
- SCAN, each edge, evaluate line L on the snapshot. The line wins if all N cells are equal and equal to 01 or 10.
  - On a win: register `win`=1, `who`=cell code, `win_line`=L, pulse `done`, go to IDLE.
  - Else if L=2N+1: register `win`=0, `draw` and `err`, pulse `done`, go to IDLE.
  - Else: L←L+1.
- `err` and `draw` are computed combinationally over the whole snapshot and registered with `done`. `err` is also registered on a win exit.
- A cell coded 11 never forms a win and is not counted as empty. `draw` is forced to 0 when `err`=1.
- If several lines win, the lowest index is reported (early exit).
- `board` changes after the start edge have no effect on the current scan.
- `start` while in SCAN is ignored; it is not queued.
- `start` held high continuously starts a new scan on the edge after `done`, because `done` occurs in IDLE.

## Timing
- Reset (async assert): every output is 0, FSM is IDLE, L=0, snapshot=0. Deassertion is synchronised externally.
- Reset asserted mid-scan: the scan is aborted immediately, no `done` pulse is issued and all outputs are 0.
- `start` accepted at edge E0 → `busy`=1 from E0.
- Line L is evaluated at edge E0+L+1.
- Winning line L: at edge E0+L+1, `done`=1 for exactly one cycle, `busy`=0, results valid.
- No winning line: `done` at E0+2N+2. Worst case is 2N+2 cycles: 8 for N=3, 18 for N=8.
- `win`, `who`, `win_line`, `draw`, `err` hold from `done` until the next accepted `start` clears them.
- All outputs are registered; no combinational path from `board` or `start` to any output.

## Test plan
- N=3, middle row = X (cells 3,4,5 = 01), start at E0 → `done` at E0+2, `win`=1, `who`=01, `win_line`=1, `draw`=0.
- N=3, anti-diagonal = O (cells 2,4,6 = 10), no other line → `done` at E0+8, `win`=1, `who`=10, `win_line`=7.
- N=3, full board X O X / X O O / O X X, no winning line → `done` at E0+8, `win`=0, `who`=00, `draw`=1, `err`=0.
- N=3, row 0 = X and column 0 = X; also cell 8 = 11 → `win_line`=0 at E0+1, `err`=1, `draw`=0.
- N=3, empty board, start; at E0+2 change `board` to a top-row X win and pulse `start` again → scan result unaffected: `done` at E0+8, `win`=0, `draw`=0. The second `start` is ignored and no second `done` follows.
- N=4 instance, column 2 = O (cells 2,6,10,14) → `done` at E0+7, `win_line`=6, `who`=10. Repeat with `rst_n` pulled low at E0+3 → outputs 0 immediately, no `done`, and the next `start` after release scans normally.
